// File: rtl/toggle_dec_pkg.sv
// Shared constants and helpers for the toggle event decoder and its synchronizer.
package toggle_dec_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_event_decoder_sync_chain.sv
// N-stage single-bit synchronizer for asynchronous level inputs; resets to 0.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes remote toggle transitions into queued events with valid/ready delivery.
// Define TGL_DEC_ACK_EN to add the ack_tgl return toggle for two-phase flow control.
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tgl_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
`ifdef TGL_DEC_ACK_EN
  ,
  output logic             ack_tgl
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_sync_depth_check
    $error("toggle_event_decoder: SYNC_STAGES must be at least 2");
  end

  logic             s_lvl;
  logic             last_q;
  logic             last_d;
  logic             tgl_edge;
  logic             take;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             ovf_q;
  logic             ovf_d;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_tgl_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (tgl_in),
    .q    (s_lvl)
  );

  assign evt_valid = (pending_q != '0);

  // A simultaneous edge and take cancel out, so a full counter never overflows then.
  always_comb begin
    last_d    = s_lvl;
    tgl_edge  = s_lvl ^ last_q;
    take      = evt_valid & evt_ready;
    pending_d = pending_q;
    ovf_d     = ovf_q & ~ovf_clr;
    if (tgl_edge && !take) begin
      if (pending_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (take && !tgl_edge) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q    <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending = pending_q;
  assign ovf     = ovf_q;

`ifdef TGL_DEC_ACK_EN
  logic ack_q;
  logic ack_d;

  always_comb begin
    ack_d = ack_q ^ take;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack_tgl = ack_q;
`endif

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed scoreboard bench for toggle_event_decoder (default parameters).
module tb_toggle_event_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             tgl_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic             ovf;
  logic             ovf_clr;
`ifdef TGL_DEC_ACK_EN
  logic             ack_tgl;
`endif

  typedef struct {
    string tag;
    int    pend;
    bit    ovf;
    bit    ack;
  } exp_t;

  exp_t scoreboard[$];
  int   passCount  = 0;
  int   checkCount = 0;
  int   failCount  = 0;
  logic tglLevel   = 1'b0;

  always #5 clk = ~clk;

  toggle_event_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tgl_in    (tgl_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef TGL_DEC_ACK_EN
    ,
    .ack_tgl   (ack_tgl)
`endif
  );

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives inputs at a falling edge, then lets the given number of cycles elapse.
  task automatic applyStimulus(input logic tgl, input logic ready, input logic clr, input int cycles);
    tgl_in    = tgl;
    evt_ready = ready;
    ovf_clr   = clr;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectOut(input string tag, input int pend, input bit ovfExp, input bit ackExp);
    exp_t e;
    e.tag  = tag;
    e.pend = pend;
    e.ovf  = ovfExp;
    e.ack  = ackExp;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = scoreboard.pop_front();
      compare({e.tag, "_pending"}, 32'(pending), 32'(e.pend));
      compare({e.tag, "_valid"}, 32'(evt_valid), 32'(e.pend != 0));
      compare({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`ifdef TGL_DEC_ACK_EN
      compare({e.tag, "_ack"}, 32'(ack_tgl), 32'(e.ack));
`endif
    end
  endtask

  initial begin
    rstn      = 1'b0;
    tgl_in    = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    expectOut("reset", 0, 1'b0, 1'b0);
    checkOutput();
    rstn = 1'b1;

    // Three toggles 4 cycles apart; first event visible exactly 3 edges later.
    tglLevel = 1'b1;
    applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    expectOut("lat_edge2", 0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    expectOut("lat_edge3", 1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    tglLevel = 1'b0;
    applyStimulus(tglLevel, 1'b0, 1'b0, 4);
    tglLevel = 1'b1;
    applyStimulus(tglLevel, 1'b0, 1'b0, 4);
    expectOut("three_events", 3, 1'b0, 1'b0);
    checkOutput();

    // Drain one per cycle.
    applyStimulus(tglLevel, 1'b1, 1'b0, 1);
    expectOut("drain_2", 2, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(tglLevel, 1'b1, 1'b0, 1);
    expectOut("drain_1", 1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(tglLevel, 1'b1, 1'b0, 1);
    expectOut("drain_0", 0, 1'b0, 1'b1);
    checkOutput();

    applyStimulus(tglLevel, 1'b1, 1'b0, 10);
    expectOut("ready_when_empty", 0, 1'b0, 1'b1);
    checkOutput();

    // Sixteen transitions saturate a 4-bit counter and the last one overflows.
    for (int i = 0; i < 16; i++) begin
      tglLevel = ~tglLevel;
      applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    end
    applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    expectOut("saturate", 15, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(tglLevel, 1'b0, 1'b1, 1);
    expectOut("ovf_clear", 15, 1'b0, 1'b1);
    checkOutput();

    // Edge and take on the same edge at full count: no overflow.
    tglLevel = ~tglLevel;
    applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    applyStimulus(tglLevel, 1'b1, 1'b0, 1);
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    expectOut("edge_and_take", 15, 1'b0, 1'b0);
    checkOutput();

    // Overflow and clear on the same edge: set wins.
    tglLevel = ~tglLevel;
    applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    applyStimulus(tglLevel, 1'b0, 1'b1, 1);
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    expectOut("set_beats_clear", 15, 1'b1, 1'b0);
    checkOutput();

    applyStimulus(tglLevel, 1'b1, 1'b0, 10);
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    expectOut("before_reset", 5, 1'b1, 1'b0);
    checkOutput();

    // Asynchronous reset mid-cycle, then release with the toggle level high.
    #2 rstn = 1'b0;
    #1;
    expectOut("async_reset", 0, 1'b0, 1'b0);
    checkOutput();
    tglLevel = 1'b1;
    tgl_in   = tglLevel;
    @(negedge clk);
    expectOut("held_in_reset", 0, 1'b0, 1'b0);
    checkOutput();
    rstn = 1'b1;
    applyStimulus(tglLevel, 1'b0, 1'b0, 2);
    expectOut("release_edge2", 0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(tglLevel, 1'b0, 1'b0, 1);
    expectOut("release_edge3", 1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(tglLevel, 1'b0, 1'b0, 6);
    expectOut("release_single", 1, 1'b0, 1'b0);
    checkOutput();

    if (scoreboard.size() != 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", scoreboard.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive-side decoder for toggle-encoded event signalling. A remote transmitter in another clock domain flips a single level (a T flip-flop driven by its event pulse) once per event. This block synchronizes that level into `clk`, turns each transition back into one event, and queues events in a saturating pending counter. It delivers them to local logic over a valid/ready handshake.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth. Legal range is 2 or more; values below 2 are an elaboration error.
- CNT_W, 4: pending-counter width. Maximum pending count is 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; asynchronous, active-low
- tgl_in  input  1  toggle level from the remote domain; asynchronous to clk
- evt_valid  output  1  at least one event is pending
- evt_ready  input  1  consumer accepts one event
- pending  output  CNT_W  number of queued events
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  synchronous clear of ovf
- ack_tgl  output  1  acknowledge toggle back to the transmitter; present only with TGL_DEC_ACK_EN

## Operation
- Reset values: synchronizer stages 0, last-level register 0, pending 0, evt_valid 0, ovf 0, ack_tgl 0. The transmitter's toggle flop must also reset to 0.
- Synchronizer: tgl_in shifts through SYNC_STAGES flops. Only the final stage (`s_lvl`) is used downstream.
- Edge detect: `edge = s_lvl ^ last`. The `last` register loads `s_lvl` every cycle. Each transition, rising or falling, counts as exactly one event.
- Consume: `take = evt_valid & evt_ready`.
- evt_valid is `(pending != 0)`, decoded directly from the registered count. It has no combinational path from evt_ready.
- Pending counter update per cycle:
  - edge only, pending < max: pending + 1.
  - edge only, pending == max: pending holds and ovf sets. The event is lost.
  - take only: pending - 1.
  - edge and take together: pending unchanged. This applies even at max, where no overflow occurs.
  - neither: hold.
- evt_ready while pending == 0 has no effect. The counter never underflows.
- ovf behaviour:
  - Stays set until ovf_clr is sampled high.
  - If ovf_clr and a new overflow occur in the same cycle, set wins.
- Reset asserted mid-operation returns all state to reset values immediately. A tgl_in level of 1 present at reset release is treated as a transition and yields one event.

## Timing
- tgl_in transition to evt_valid high: SYNC_STAGES+1 rising clk edges. With the default of 2 this is 3 edges, counting from the first edge that samples the new level.
- Minimum spacing between tgl_in transitions for lossless capture: 2 clk periods, so the synchronizer sees every level.
- take to pending decrement: 1 edge. evt_valid falls on the same edge once pending reaches 0.
- Back-to-back consumption is 1 event per cycle while evt_ready is held high.
- ovf asserts on the edge that drops the event. ovf_clr takes effect on the next edge.

## Configuration
- TGL_DEC_ACK_EN defined:
  - The ack_tgl port exists. It is a registered flop that inverts on every take cycle.
  - The transmitter compares ack_tgl against its own toggle to learn outstanding events, giving two-phase flow control.
  - ack_tgl changes 1 edge after the take cycle.
- TGL_DEC_ACK_EN undefined: the port and flop are absent. Events are fire-and-forget, and ovf is the only loss indication.

## Structure
- Package `toggle_dec_pkg`:
  - constant `SYNC_STAGES_MIN = 2`.
  - function `cnt_max(width)` returning 2^width-1.
- Sub-module `sync_chain`:
  - Parameterized N-stage single-bit synchronizer with asynchronous active-low reset to 0.
  - Instanced once for tgl_in. Reusable elsewhere for CDC.
- The top level holds edge detect, counter, ovf and ack.

## Test plan
- Reset, then 3 tgl_in transitions spaced 4 cycles apart with evt_ready=0 → pending reaches 3, evt_valid=1, and the first assertion is exactly 3 edges after the first transition.
- pending=3, evt_ready held high → pending steps 2,1,0 on consecutive edges, evt_valid drops with 0, and with ACK_EN ack_tgl toggles 3 times (final value 1).
- 16 transitions with CNT_W=4 and evt_ready=0 → pending saturates at 15 and ovf=1 after the 16th. ovf_clr pulse → ovf=0 and pending stays 15.
- pending=15 with an edge and a take in the same cycle → pending stays 15 and ovf stays 0. Repeat with ovf_clr and an overflow together → ovf=1.
- evt_ready=1 with pending=0 for 10 cycles → pending stays 0 and ack_tgl does not change.
- rstn pulsed low while pending=5 and ovf=1 → all outputs go to 0 asynchronously. tgl_in=1 at release → exactly one event appears SYNC_STAGES+1 edges later.
